// File: rtl/region_attr_table.sv
// region_attr_table
//   Address region attribute lookup. The table holds NumRules rules, each with a
//   base, a length and an attribute byte. A lookup returns the lowest-index rule
//   whose [base, base+length) window contains the address. The result is
//   registered one stage deep with valid/ready handshaking.
//
//   Config map, one 64-bit word per index:
//     3i   : base[i]
//     3i+1 : length[i]
//     3i+2 : attr[i]  bits[3:0] attributes, bit 7 rule lock (sticky)
//     3N   : control  bit 0 global lock (sticky)
//     3N+1 : miss counter (only with REGION_ATTR_MISS_CNT_EN defined)
//
//   Optional feature macro: REGION_ATTR_MISS_CNT_EN adds a 32-bit saturating
//   counter of accepted lookups that missed every rule.
//
// Ports
//   clk_i, rst_ni                      clock, asynchronous active-low reset
//   cfg_req_i/we_i/addr_i/wdata_i      config access (word index addressing)
//   cfg_rdata_o, cfg_err_o             read data / error, one cycle after the access
//   req_valid_i/ready_o/addr_i         lookup request
//   rsp_valid_o/ready_i                lookup response handshake
//   rsp_hit_o/idx_o/attr_o             match flag, rule index, {shared,cached,exec,idempotent}
module region_attr_table #(
  parameter int unsigned                   NumRules  = 5,
  parameter int unsigned                   AddrWidth = 64,
  parameter logic [NumRules*AddrWidth-1:0] RstBase   = '0,
  parameter logic [NumRules*AddrWidth-1:0] RstLength = '0,
  parameter logic [NumRules*8-1:0]         RstAttr   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_req_i,
  input  logic                 cfg_we_i,
  input  logic [5:0]           cfg_addr_i,
  input  logic [63:0]          cfg_wdata_i,
  output logic [63:0]          cfg_rdata_o,
  output logic                 cfg_err_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [3:0]           rsp_idx_o,
  output logic [3:0]           rsp_attr_o
);

  localparam logic [5:0] CtrlWord = 6'(3 * NumRules);

  // Rule table
  logic [AddrWidth-1:0] r_base   [NumRules];
  logic [AddrWidth-1:0] r_length [NumRules];
  logic [3:0]           r_attr   [NumRules];
  logic [NumRules-1:0]  r_rlock;
  logic                 r_glock;

  // Registered outputs
  logic [63:0] r_cfg_rdata;
  logic        r_cfg_err;
  logic        r_rsp_valid;
  logic        r_rsp_hit;
  logic [3:0]  r_rsp_idx;
  logic [3:0]  r_rsp_attr;

  logic [63:0]         w_rdata;
  logic                w_in_map;
  logic                w_locked;
  logic                w_err;
  logic                w_wr;
  logic [NumRules-1:0] w_match;
  logic                w_hit;
  logic [3:0]          w_idx;
  logic [3:0]          w_attr;
  logic                w_accept;

`ifdef REGION_ATTR_MISS_CNT_EN
  localparam logic [5:0] CntWord = 6'(3 * NumRules + 1);
  logic [31:0] r_miss_cnt;
`endif

  // Config decode: read mux, map membership and write protection
  always_comb begin
    w_rdata  = '0;
    w_in_map = 1'b0;
    w_locked = 1'b0;
    for (int i = 0; i < NumRules; i++) begin
      if (cfg_addr_i == 6'(3 * i)) begin
        w_rdata  = 64'(r_base[i]);
        w_in_map = 1'b1;
        w_locked = r_rlock[i] | r_glock;
      end
      if (cfg_addr_i == 6'(3 * i + 1)) begin
        w_rdata  = 64'(r_length[i]);
        w_in_map = 1'b1;
        w_locked = r_rlock[i] | r_glock;
      end
      if (cfg_addr_i == 6'(3 * i + 2)) begin
        w_rdata  = {56'd0, r_rlock[i], 3'd0, r_attr[i]};
        w_in_map = 1'b1;
        w_locked = r_rlock[i] | r_glock;
      end
    end
    // Control word is always writable; the lock bit can only be set (sticky).
    if (cfg_addr_i == CtrlWord) begin
      w_rdata  = {63'd0, r_glock};
      w_in_map = 1'b1;
    end
`ifdef REGION_ATTR_MISS_CNT_EN
    if (cfg_addr_i == CntWord) begin
      w_rdata  = {32'd0, r_miss_cnt};
      w_in_map = 1'b1;
      w_locked = r_glock;
    end
`endif
  end

  assign w_err = !w_in_map || (cfg_we_i && w_locked);
  assign w_wr  = cfg_req_i && cfg_we_i && w_in_map && !w_locked;

  // Table and config response registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRules; i++) begin
        r_base[i]   <= RstBase[i*AddrWidth +: AddrWidth];
        r_length[i] <= RstLength[i*AddrWidth +: AddrWidth];
        r_attr[i]   <= RstAttr[i*8 +: 4];
        r_rlock[i]  <= RstAttr[i*8 + 7];
      end
      r_glock     <= 1'b0;
      r_cfg_rdata <= '0;
      r_cfg_err   <= 1'b0;
    end else begin
      if (w_wr) begin
        for (int i = 0; i < NumRules; i++) begin
          if (cfg_addr_i == 6'(3 * i))     r_base[i]   <= cfg_wdata_i[AddrWidth-1:0];
          if (cfg_addr_i == 6'(3 * i + 1)) r_length[i] <= cfg_wdata_i[AddrWidth-1:0];
          if (cfg_addr_i == 6'(3 * i + 2)) begin
            r_attr[i]  <= cfg_wdata_i[3:0];
            r_rlock[i] <= cfg_wdata_i[7];
          end
        end
        if (cfg_addr_i == CtrlWord) r_glock <= r_glock | cfg_wdata_i[0];
      end
      r_cfg_rdata <= cfg_req_i ? w_rdata : '0;
      r_cfg_err   <= cfg_req_i && w_err;
    end
  end

  // Per-rule window match; addr >= base guarantees the subtraction never wraps.
  generate
    for (genvar gi = 0; gi < NumRules; gi++) begin : g_match
      assign w_match[gi] = (r_length[gi] != '0) &&
                           (req_addr_i >= r_base[gi]) &&
                           ((req_addr_i - r_base[gi]) < r_length[gi]);
    end
  endgenerate

  // Lowest index wins: scan downwards so the last assignment is the lowest match.
  always_comb begin
    w_hit  = 1'b0;
    w_idx  = '0;
    w_attr = '0;
    for (int i = NumRules - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit  = 1'b1;
        w_idx  = 4'(i);
        w_attr = r_attr[i];
      end
    end
  end

  assign req_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_accept    = req_valid_i && req_ready_o;

  // Response stage; the match uses the table before any same-cycle write lands.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rsp_valid <= 1'b0;
      r_rsp_hit   <= 1'b0;
      r_rsp_idx   <= '0;
      r_rsp_attr  <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_hit   <= w_hit;
      r_rsp_idx   <= w_idx;
      r_rsp_attr  <= w_attr;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

`ifdef REGION_ATTR_MISS_CNT_EN
  // Saturating miss counter; a clearing write takes priority over an increment.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_miss_cnt <= '0;
    end else if (w_wr && (cfg_addr_i == CntWord)) begin
      r_miss_cnt <= '0;
    end else if (w_accept && !w_hit && (r_miss_cnt != '1)) begin
      r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end
`endif

  assign cfg_rdata_o = r_cfg_rdata;
  assign cfg_err_o   = r_cfg_err;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_hit_o   = r_rsp_hit;
  assign rsp_idx_o   = r_rsp_idx;
  assign rsp_attr_o  = r_rsp_attr;

endmodule

// File: tb/tb_region_attr_table.sv
// Directed testbench for region_attr_table (default NumRules=5, AddrWidth=64).
// Rule 2 has a non-zero reset base (0x5000) so reset restoration is visible.
module tb_region_attr_table;

  localparam int unsigned NR = 5;
  localparam int unsigned AW = 64;
  localparam logic [NR*AW-1:0] TbRstBase = (320'h5000 << 128);

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cfg_req_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [5:0]  cfg_addr_i = '0;
  logic [63:0] cfg_wdata_i = '0;
  logic [63:0] cfg_rdata_o;
  logic        cfg_err_o;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [63:0] req_addr_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic        rsp_hit_o;
  logic [3:0]  rsp_idx_o;
  logic [3:0]  rsp_attr_o;

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  region_attr_table #(
    .NumRules (NR),
    .AddrWidth(AW),
    .RstBase  (TbRstBase),
    .RstLength('0),
    .RstAttr  ('0)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cfg_req_i  (cfg_req_i),
    .cfg_we_i   (cfg_we_i),
    .cfg_addr_i (cfg_addr_i),
    .cfg_wdata_i(cfg_wdata_i),
    .cfg_rdata_o(cfg_rdata_o),
    .cfg_err_o  (cfg_err_o),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_hit_o  (rsp_hit_o),
    .rsp_idx_o  (rsp_idx_o),
    .rsp_attr_o (rsp_attr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One config access; returns rdata/err seen the cycle after the strobe.
  task automatic cfg(input logic we, input logic [5:0] a, input logic [63:0] d,
                     output logic [63:0] rd, output logic er);
    @(negedge clk_i);
    cfg_req_i = 1'b1; cfg_we_i = we; cfg_addr_i = a; cfg_wdata_i = d;
    @(negedge clk_i);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0;
    rd = cfg_rdata_o; er = cfg_err_o;
    $display("cfg %s word=%0d data=0x%0h -> rdata=0x%0h err=%0b",
             we ? "WR" : "RD", a, d, rd, er);
  endtask

  // One lookup with rsp_ready_i high; returns the registered response.
  task automatic lookup(input logic [63:0] a, output logic v, output logic h,
                        output logic [3:0] ix, output logic [3:0] at);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = a;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    v = rsp_valid_o; h = rsp_hit_o; ix = rsp_idx_o; at = rsp_attr_o;
    $display("lookup addr=0x%0h -> valid=%0b hit=%0b idx=%0d attr=0x%0h", a, v, h, ix, at);
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    logic        v, h;
    logic [3:0]  ix, at;

    // Reset state
    #3;
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_hit",   64'(rsp_hit_o), 64'd0);
    chk("rst_cfg_err",   64'(cfg_err_o), 64'd0);
    chk("rst_rdata",     cfg_rdata_o, 64'd0);
    chk("rst_ready",     64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    cfg(1'b0, 6'd6, 64'd0, rd, er);
    chk("rst_base2", rd, 64'h5000);

    // Rule 0: [0x8000_0000, 0xC000_0000), all attributes
    cfg(1'b1, 6'd0, 64'h8000_0000, rd, er); chk("wr_base0_err", 64'(er), 64'd0);
    cfg(1'b1, 6'd1, 64'h4000_0000, rd, er);
    cfg(1'b1, 6'd2, 64'hFFFF_FF7F, rd, er);
    cfg(1'b0, 6'd2, 64'd0, rd, er);         chk("attr0_unused_bits", rd, 64'hF);
    lookup(64'hBFFF_FFFF, v, h, ix, at);
    chk("r0_top_valid", 64'(v), 64'd1);
    chk("r0_top_hit", 64'(h), 64'd1);
    chk("r0_top_idx", 64'(ix), 64'd0);
    chk("r0_top_attr", 64'(at), 64'hF);
    lookup(64'hC000_0000, v, h, ix, at);
    chk("r0_end_hit", 64'(h), 64'd0);
    chk("r0_end_idx", 64'(ix), 64'd0);
    chk("r0_end_attr", 64'(at), 64'h0);
    lookup(64'h8000_0000, v, h, ix, at);
    chk("r0_base_hit", 64'(h), 64'd1);
    lookup(64'h7FFF_FFFF, v, h, ix, at);
    chk("r0_below_hit", 64'(h), 64'd0);

    // Rule 1 covers low 4 GiB; rule 3 overlaps it
    cfg(1'b1, 6'd3, 64'h0, rd, er);
    cfg(1'b1, 6'd4, 64'h1_0000_0000, rd, er);
    cfg(1'b1, 6'd5, 64'h1, rd, er);
    cfg(1'b1, 6'd9, 64'h0, rd, er);
    cfg(1'b1, 6'd10, 64'h1_0000, rd, er);
    cfg(1'b1, 6'd11, 64'h6, rd, er);
    lookup(64'h1000, v, h, ix, at);
    chk("ovl_idx", 64'(ix), 64'd1);
    chk("ovl_attr", 64'(at), 64'h1);
    lookup(64'h9000_0000, v, h, ix, at);
    chk("r0_beats_r1_idx", 64'(ix), 64'd0);
    chk("r0_beats_r1_attr", 64'(at), 64'hF);
    lookup(64'hFFFF_FFFF_FFFF_FFFF, v, h, ix, at);
    chk("max_addr_hit", 64'(h), 64'd0);

    // Back-pressure: A accepted, B held for 3 cycles, then released
    @(negedge clk_i);
    rsp_ready_i = 1'b0; req_valid_i = 1'b1; req_addr_i = 64'h1000;
    @(negedge clk_i);
    req_addr_i = 64'h8000_0000;
    chk("bp_a_valid", 64'(rsp_valid_o), 64'd1);
    chk("bp_a_idx", 64'(rsp_idx_o), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      $display("stall cycle %0d: ready=%0b valid=%0b idx=%0d attr=0x%0h",
               k, req_ready_o, rsp_valid_o, rsp_idx_o, rsp_attr_o);
      chk("bp_ready_low", 64'(req_ready_o), 64'd0);
      chk("bp_idx_stable", 64'(rsp_idx_o), 64'd1);
      chk("bp_attr_stable", 64'(rsp_attr_o), 64'h1);
    end
    rsp_ready_i = 1'b1;
    #1;
    chk("bp_ready_release", 64'(req_ready_o), 64'd1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    chk("bp_b_valid", 64'(rsp_valid_o), 64'd1);
    chk("bp_b_idx", 64'(rsp_idx_o), 64'd0);
    chk("bp_b_attr", 64'(rsp_attr_o), 64'hF);
    @(negedge clk_i);
    chk("bp_no_dup", 64'(rsp_valid_o), 64'd0);

    // Same-cycle length write and lookup: old length applies to this lookup
    @(negedge clk_i);
    cfg_req_i = 1'b1; cfg_we_i = 1'b1; cfg_addr_i = 6'd1; cfg_wdata_i = 64'h10;
    req_valid_i = 1'b1; req_addr_i = 64'hBFFF_FFF0;
    @(negedge clk_i);
    cfg_req_i = 1'b0; cfg_we_i = 1'b0; req_valid_i = 1'b0;
    $display("concurrent wr len0=0x10 + lookup 0xbffffff0 -> hit=%0b idx=%0d attr=0x%0h",
             rsp_hit_o, rsp_idx_o, rsp_attr_o);
    chk("prewrite_idx", 64'(rsp_idx_o), 64'd0);
    chk("prewrite_attr", 64'(rsp_attr_o), 64'hF);
    lookup(64'hBFFF_FFF0, v, h, ix, at);
    chk("postwrite_idx", 64'(ix), 64'd1);
    chk("postwrite_attr", 64'(at), 64'h1);

    // Miss counter word
`ifdef REGION_ATTR_MISS_CNT_EN
    cfg(1'b1, 6'd16, 64'd0, rd, er);
    chk("cnt_clr_err", 64'(er), 64'd0);
    for (int k = 0; k < 5; k++) lookup(64'hFFFF_FFFF_0000_0000 + 64'(k), v, h, ix, at);
    cfg(1'b0, 6'd16, 64'd0, rd, er);
    chk("cnt_five", rd, 64'd5);
    chk("cnt_rd_err", 64'(er), 64'd0);
    cfg(1'b1, 6'd16, 64'd123, rd, er);
    cfg(1'b0, 6'd16, 64'd0, rd, er);
    chk("cnt_cleared", rd, 64'd0);
`else
    for (int k = 0; k < 5; k++) lookup(64'hFFFF_FFFF_0000_0000 + 64'(k), v, h, ix, at);
    cfg(1'b0, 6'd16, 64'd0, rd, er);
    chk("cnt_absent_rdata", rd, 64'd0);
    chk("cnt_absent_err", 64'(er), 64'd1);
`endif

    // Out-of-range accesses
    cfg(1'b0, 6'd17, 64'd0, rd, er);
    chk("oor_rd_rdata", rd, 64'd0);
    chk("oor_rd_err", 64'(er), 64'd1);
    cfg(1'b1, 6'd40, 64'hDEAD, rd, er);
    chk("oor_wr_err", 64'(er), 64'd1);

    // Rule lock and global lock
    cfg(1'b1, 6'd8, 64'h80, rd, er);      chk("lock2_set_err", 64'(er), 64'd0);
    cfg(1'b1, 6'd6, 64'h1234, rd, er);    chk("lock2_wr_err", 64'(er), 64'd1);
    cfg(1'b0, 6'd6, 64'd0, rd, er);       chk("lock2_base_kept", rd, 64'h5000);
    cfg(1'b1, 6'd8, 64'h0, rd, er);       chk("lock2_attr_wr_err", 64'(er), 64'd1);
    cfg(1'b0, 6'd8, 64'd0, rd, er);       chk("lock2_attr_rd", rd, 64'h80);
    cfg(1'b1, 6'd15, 64'h1, rd, er);      chk("glock_set_err", 64'(er), 64'd0);
    cfg(1'b1, 6'd0, 64'h0, rd, er);       chk("glock_wr_err", 64'(er), 64'd1);
    cfg(1'b0, 6'd0, 64'd0, rd, er);       chk("glock_base0_kept", rd, 64'h8000_0000);
    cfg(1'b1, 6'd15, 64'h0, rd, er);
    cfg(1'b0, 6'd15, 64'd0, rd, er);      chk("glock_sticky", rd, 64'h1);

    // Reset with a response in flight: dropped, table restored
    @(negedge clk_i);
    req_valid_i = 1'b1; req_addr_i = 64'h1000;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    req_valid_i = 1'b0;
    chk("inflight_valid_dropped", 64'(rsp_valid_o), 64'd0);
    chk("inflight_hit_cleared", 64'(rsp_hit_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_no_rsp", 64'(rsp_valid_o), 64'd0);
    cfg(1'b0, 6'd15, 64'd0, rd, er);      chk("rst_glock_clear", rd, 64'd0);
    cfg(1'b0, 6'd6, 64'd0, rd, er);       chk("rst_base2_restored", rd, 64'h5000);
    cfg(1'b0, 6'd0, 64'd0, rd, er);       chk("rst_base0_restored", rd, 64'd0);
    cfg(1'b0, 6'd8, 64'd0, rd, er);       chk("rst_lock2_clear", rd, 64'd0);
    cfg(1'b1, 6'd6, 64'h1234, rd, er);    chk("rst_unlocked_wr_err", 64'(er), 64'd0);
    cfg(1'b0, 6'd6, 64'd0, rd, er);       chk("rst_unlocked_rd", rd, 64'h1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
